// File: rtl/timer_counter_core.sv
// timer_counter_core: prescaled event counter with shadowed start/end thresholds.
// Sawtooth mode restarts at start after reaching end; up/down mode bounces
// between start and end. evt_o pulses for one cycle at every turning point.
module timer_counter_core #(
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ctrl_active_i,
  input  logic               ctrl_update_i,
  input  logic               ctrl_rst_i,
  input  logic [CNT_W-1:0]   cfg_start_i,
  input  logic [CNT_W-1:0]   cfg_end_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  input  logic               cfg_sawtooth_i,
  input  logic               event_i,
  output logic [CNT_W-1:0]   counter_o,
  output logic               dir_o,
  output logic               evt_o
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   end_q, end_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               saw_q, saw_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               evt_q, evt_d;
  logic               tick;

  // Next-state: update beats restart beats tick; evt defaults low every cycle.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    presc_d = presc_q;
    saw_d   = saw_q;
    pcnt_d  = pcnt_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    evt_d   = 1'b0;
    tick    = 1'b0;

    if (ctrl_update_i) begin
      start_d = cfg_start_i;
      end_d   = cfg_end_i;
      presc_d = cfg_presc_i;
      saw_d   = cfg_sawtooth_i;
      pcnt_d  = '0;
      cnt_d   = cfg_start_i;
      dir_d   = 1'b0;
    end else if (ctrl_rst_i) begin
      pcnt_d  = '0;
      cnt_d   = start_q;
      dir_d   = 1'b0;
    end else if (ctrl_active_i && event_i) begin
      if (pcnt_q == presc_q) begin
        pcnt_d = '0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRESC_ONE;
      end
    end

    if (tick) begin
      if (saw_q) begin
        // Sawtooth: start==end naturally holds at start and pulses every tick.
        if (cnt_q == end_q) begin
          cnt_d = start_q;
          evt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (!dir_q && (cnt_q == end_q)) begin
        evt_d = 1'b1;
        if (start_q == end_q) begin
          cnt_d = cnt_q;
        end else begin
          dir_d = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
        end
      end else if (dir_q && (cnt_q == start_q)) begin
        evt_d = 1'b1;
        dir_d = 1'b0;
        cnt_d = cnt_q + CNT_ONE;
      end else if (dir_q) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q <= '0;
      end_q   <= '0;
      presc_q <= '0;
      saw_q   <= 1'b1;
      pcnt_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      presc_q <= presc_d;
      saw_q   <= saw_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      evt_q   <= evt_d;
    end
  end

  assign counter_o = cnt_q;
  assign dir_o     = dir_q;
  assign evt_o     = evt_q;

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core; inputs change on the falling edge,
// outputs are sampled on the following falling edge.
module tb_timer_counter_core;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        ctrl_active_i = 1'b0;
  logic        ctrl_update_i = 1'b0;
  logic        ctrl_rst_i = 1'b0;
  logic [15:0] cfg_start_i = '0;
  logic [15:0] cfg_end_i = '0;
  logic [7:0]  cfg_presc_i = '0;
  logic        cfg_sawtooth_i = 1'b1;
  logic        event_i = 1'b0;
  logic [15:0] counter_o;
  logic        dir_o;
  logic        evt_o;

  int n_chk = 0;
  int n_pass = 0;

  timer_counter_core #(.CNT_W(16), .PRESC_W(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ctrl_active_i(ctrl_active_i),
    .ctrl_update_i(ctrl_update_i), .ctrl_rst_i(ctrl_rst_i),
    .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i), .cfg_presc_i(cfg_presc_i),
    .cfg_sawtooth_i(cfg_sawtooth_i), .event_i(event_i),
    .counter_o(counter_o), .dir_o(dir_o), .evt_o(evt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock with event_i = e, then back on the falling edge.
  task automatic step(input logic e);
    event_i = e;
    @(negedge clk_i);
    event_i = 1'b0;
  endtask

  task automatic update(input logic [15:0] s, input logic [15:0] en,
                        input logic [7:0] p, input logic saw);
    cfg_start_i = s; cfg_end_i = en; cfg_presc_i = p; cfg_sawtooth_i = saw;
    ctrl_update_i = 1'b1;
    step(1'b0);
    ctrl_update_i = 1'b0;
  endtask

  logic [15:0] saw_exp [10] = '{3, 4, 5, 2, 3, 4, 5, 2, 3, 4};
  logic [15:0] ud_cnt  [9]  = '{2, 3, 2, 1, 2, 3, 2, 1, 2};
  logic        ud_dir  [9]  = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  logic        ud_evt  [9]  = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [15:0] wr_exp  [4]  = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE};

  initial begin
    #2;
    chk("reset_cnt", counter_o, 0);
    chk("reset_dir", dir_o, 0);
    chk("reset_evt", evt_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    ctrl_active_i = 1'b1;
    @(negedge clk_i);

    // Sawtooth 2..5
    update(16'd2, 16'd5, 8'd0, 1'b1);
    chk("saw_load", counter_o, 2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      chk($sformatf("saw_cnt%0d", i), counter_o, saw_exp[i]);
      chk($sformatf("saw_evt%0d", i), evt_o, (saw_exp[i] == 16'd2));
    end
    step(1'b0);
    chk("saw_idle_evt", evt_o, 0);

    // Prescaler: one increment every 4th event
    update(16'd0, 16'd100, 8'd3, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      chk($sformatf("presc_cnt%0d", i), counter_o, i / 4);
      chk($sformatf("presc_evt%0d", i), evt_o, 0);
    end

    // Up/down 1..3
    update(16'd1, 16'd3, 8'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b1);
      chk($sformatf("ud_cnt%0d", i), counter_o, ud_cnt[i]);
      chk($sformatf("ud_dir%0d", i), dir_o, ud_dir[i]);
      chk($sformatf("ud_evt%0d", i), evt_o, ud_evt[i]);
    end

    // Degenerate start == end, both modes
    update(16'd7, 16'd7, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("deg_saw_cnt", counter_o, 7);
      chk("deg_saw_evt", evt_o, 1);
    end
    update(16'd7, 16'd7, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk("deg_ud_cnt", counter_o, 7);
      chk("deg_ud_dir", dir_o, 0);
      chk("deg_ud_evt", evt_o, 1);
    end

    // Update in the same cycle as an event that would otherwise pulse
    cfg_start_i = 16'd10; cfg_end_i = 16'd10; cfg_presc_i = 8'd0; cfg_sawtooth_i = 1'b1;
    ctrl_update_i = 1'b1;
    step(1'b1);
    ctrl_update_i = 1'b0;
    chk("upd_evt_cnt", counter_o, 10);
    chk("upd_evt_evt", evt_o, 0);

    // Wrap through 0xFFFF with start > end
    update(16'hFFFE, 16'h0001, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      chk($sformatf("wrap_cnt%0d", i), counter_o, wr_exp[i]);
      chk($sformatf("wrap_evt%0d", i), evt_o, (i == 3));
    end

    // Inactive: events ignored
    update(16'd20, 16'd30, 8'd0, 1'b1);
    step(1'b1);
    chk("act_base", counter_o, 21);
    ctrl_active_i = 1'b0;
    step(1'b1);
    step(1'b1);
    chk("inact_cnt", counter_o, 21);
    chk("inact_evt", evt_o, 0);
    ctrl_active_i = 1'b1;

    // cfg changes without update have no effect; restart uses shadow start
    cfg_start_i = 16'd99; cfg_end_i = 16'd22;
    step(1'b1);
    step(1'b1);
    chk("noupd_cnt", counter_o, 23);
    chk("noupd_evt", evt_o, 0);
    ctrl_rst_i = 1'b1;
    step(1'b1);
    ctrl_rst_i = 1'b0;
    chk("rst_cnt", counter_o, 20);
    chk("rst_dir", dir_o, 0);

    // Async reset mid-count with counter 0x42, dir 1
    update(16'h41, 16'h43, 8'd0, 1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    chk("pre_arst_cnt", counter_o, 16'h42);
    chk("pre_arst_dir", dir_o, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_cnt", counter_o, 0);
    chk("arst_dir", dir_o, 0);
    chk("arst_evt", evt_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(1'b1);
    chk("post_arst_cnt", counter_o, 0);
    update(16'd5, 16'd9, 8'd0, 1'b1);
    step(1'b1);
    chk("resume_cnt", counter_o, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
